// File: rtl/byte_bank_pkg.sv
// Shared defaults and the read-pointer wrap helper for the byte_bank_rw register bank.
package byte_bank_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;

  // Advance a sequential read pointer, wrapping from depth-1 back to zero.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr >= (depth - 32'd1)) ? 32'd0 : (ptr + 32'd1);
  endfunction

endpackage

// File: rtl/bank_read_mux.sv
// Combinational DEPTH:1 entry selector over a flattened entry vector.
// Flags indices at or beyond DEPTH and returns zero for them.
module bank_read_mux
  import byte_bank_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH*DATA_W-1:0] entries_i,
  input  logic [ADDR_W-1:0]       sel_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    oor_o
);

  // Select the addressed entry; non-existent indices fall through to zero.
  always_comb begin
    data_o = '0;
    oor_o  = (32'(sel_i) >= 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      data_o = (sel_i == ADDR_W'(i)) ? entries_i[i*DATA_W +: DATA_W] : data_o;
    end
  end

endmodule

// File: rtl/byte_bank_rw.sv
// Register bank with one-hot write, registered random/sequential reads and read-valid.
// Build option: define WR_BYPASS_EN for write-first same-cycle reads (default read-first).
module byte_bank_rw
  import byte_bank_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_sel,
  input  logic              seq_mode,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [ADDR_W-1:0] rd_ptr
);

  logic [DEPTH*DATA_W-1:0] entries_q, entries_d, mux_entries_s;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d, mux_data_s;
  logic                    rd_valid_q, rd_valid_d, rd_err_q, rd_err_d, mux_oor_s;
  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d, eff_sel_s;

  // Next entry contents: clear beats write; indices beyond DEPTH match no entry.
  always_comb begin
    entries_d = entries_q;
    if (clear) begin
      entries_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i*DATA_W +: DATA_W] = (wr_en && (wr_sel == ADDR_W'(i))) ?
                                        wr_data : entries_q[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef WR_BYPASS_EN
  assign mux_entries_s = entries_d;
`else
  assign mux_entries_s = entries_q;
`endif

  assign eff_sel_s = seq_mode ? rd_ptr_q : rd_sel;

  bank_read_mux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_read_mux (
    .entries_i (mux_entries_s),
    .sel_i     (eff_sel_s),
    .data_o    (mux_data_s),
    .oor_o     (mux_oor_s)
  );

  // Read-side next state; rd_data holds when no read is requested.
  always_comb begin
    rd_valid_d = rd_en;
    rd_err_d   = rd_en & mux_oor_s & ~seq_mode;
    rd_data_d  = rd_en ? mux_data_s : rd_data_q;
    if (rd_en && seq_mode) begin
      rd_ptr_d = ADDR_W'(next_ptr(32'(rd_ptr_q), 32'(DEPTH)));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_ptr_q   <= '0;
    end else begin
      entries_q  <= entries_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_ptr   = rd_ptr_q;

endmodule

// File: tb/tb_byte_bank_rw.sv
// Directed self-checking bench for byte_bank_rw: a DEPTH=4 and a DEPTH=5 instance.
module tb_byte_bank_rw;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0, seq_mode = 1'b0, tgt5 = 1'b0;
  logic [2:0] wr_sel = 3'd0, rd_sel = 3'd0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] rd_data4, rd_data5;
  logic       rd_valid4, rd_valid5, rd_err4, rd_err5;
  logic [1:0] rd_ptr4;
  logic [2:0] rd_ptr5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_bank_rw #(.DATA_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_en(wr_en & ~tgt5), .wr_sel(wr_sel[1:0]), .wr_data(wr_data),
    .rd_en(rd_en & ~tgt5), .rd_sel(rd_sel[1:0]), .seq_mode(seq_mode),
    .rd_data(rd_data4), .rd_valid(rd_valid4), .rd_err(rd_err4), .rd_ptr(rd_ptr4)
  );

  byte_bank_rw #(.DATA_W(8), .DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_en(wr_en & tgt5), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en & tgt5), .rd_sel(rd_sel), .seq_mode(seq_mode),
    .rd_data(rd_data5), .rd_valid(rd_valid5), .rd_err(rd_err5), .rd_ptr(rd_ptr5)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel);
    rd_en = 1'b1; rd_sel = sel;
    tick();
    rd_en = 1'b0;
  endtask

  logic [7:0] seq4_data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
  logic [1:0] seq4_ptr  [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [7:0] seq5_data [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h10};
  logic [2:0] seq5_ptr  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

  initial begin
    #3;
    check_val("rst_data", 32'(rd_data4), 32'h0);
    check_val("rst_valid", 32'(rd_valid4), 32'h0);
    check_val("rst_err", 32'(rd_err4), 32'h0);
    check_val("rst_ptr", 32'(rd_ptr4), 32'h0);
    #9 rst_n = 1'b1;

    // 1: fill and random read
    wr(3'd0, 8'h11); wr(3'd1, 8'h22); wr(3'd2, 8'h33); wr(3'd3, 8'h44);
    rd(3'd2);
    check_val("rand_valid", 32'(rd_valid4), 32'h1);
    check_val("rand_data", 32'(rd_data4), 32'h33);
    check_val("rand_err", 32'(rd_err4), 32'h0);
    tick();
    check_val("idle_valid", 32'(rd_valid4), 32'h0);
    check_val("idle_hold", 32'(rd_data4), 32'h33);

    // 2: sequential streaming with wrap
    seq_mode = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("seq4_data", 32'(rd_data4), 32'(seq4_data[i]));
      check_val("seq4_ptr", 32'(rd_ptr4), 32'(seq4_ptr[i]));
    end
    rd_en = 1'b0; seq_mode = 1'b0;

    // 3: same-cycle write and read of entry 1
    wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'hAA; rd_en = 1'b1; rd_sel = 3'd1;
    tick();
`ifdef WR_BYPASS_EN
    check_val("rw_same", 32'(rd_data4), 32'hAA);
`else
    check_val("rw_same", 32'(rd_data4), 32'h22);
`endif
    wr_en = 1'b0;
    tick();
    check_val("rw_after", 32'(rd_data4), 32'hAA);
    rd_en = 1'b0;

    // 4: clear beats write, pointer untouched
    clear = 1'b1; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h55;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(3'(i));
      check_val("clr_data", 32'(rd_data4), 32'h0);
    end
    check_val("clr_ptr", 32'(rd_ptr4), 32'h2);

    // 5: DEPTH=5 out-of-range and wrap
    tgt5 = 1'b1;
    for (int i = 0; i < 5; i++) wr(3'(i), 8'h10 + 8'(i));
    wr(3'd7, 8'hEE);
    rd(3'd6);
    check_val("oor_valid", 32'(rd_valid5), 32'h1);
    check_val("oor_err", 32'(rd_err5), 32'h1);
    check_val("oor_data", 32'(rd_data5), 32'h0);
    for (int i = 0; i < 5; i++) begin
      rd(3'(i));
      check_val("d5_data", 32'(rd_data5), 32'h10 + 32'(i));
      check_val("d5_err", 32'(rd_err5), 32'h0);
    end
    seq_mode = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("seq5_data", 32'(rd_data5), 32'(seq5_data[i]));
      check_val("seq5_ptr", 32'(rd_ptr5), 32'(seq5_ptr[i]));
    end
    rd_en = 1'b0; seq_mode = 1'b0; tgt5 = 1'b0;

    // 6: async reset mid-stream
    wr(3'd0, 8'h5A);
    seq_mode = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_val("pre_rst_ptr", 32'(rd_ptr4), 32'h2);
    check_val("pre_rst_valid", 32'(rd_valid4), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(rd_valid4), 32'h0);
    check_val("arst_data", 32'(rd_data4), 32'h0);
    check_val("arst_ptr", 32'(rd_ptr4), 32'h0);
    rd_en = 1'b0; seq_mode = 1'b0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(3'(i));
      check_val("post_rst_data", 32'(rd_data4), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
